// File: rtl/ptw_arb_pkg.sv
// Shared definitions for the two-client page-table-walker arbiter.
// Holds the FSM encoding, bus widths and the fault PTE value.
package ptw_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int VADDR_W = 32;
    localparam int PTE_W   = 32;

    // An all-zero PTE is the walker's fault indication.
    localparam logic [PTE_W-1:0] PTE_FAULT = 32'h0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

endpackage

// File: rtl/ptw_arbiter_rr_arb2.sv
// Two-way round-robin grant logic for the PTW arbiter.
// A lone requester always wins; on a tie the requester that was not
// served last wins. The grant is purely combinational.
module rr_arb2
    import ptw_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic               last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               grant_idx_o
);

    // Pick the winner index, then expand it to a one-hot grant
    always_comb begin
        grant_idx_o = 1'b0;
        if (req_valid_i == 2'b11) begin
            grant_idx_o = ~last_grant_i;
        end else if (req_valid_i == 2'b10) begin
            grant_idx_o = 1'b1;
        end
        if (req_valid_i == 2'b00) begin
            grant_o = 2'b00;
        end else if (grant_idx_o) begin
            grant_o = 2'b10;
        end else begin
            grant_o = 2'b01;
        end
    end

endmodule

// File: rtl/ptw_arbiter.sv
// Shares one page-table walker between the ITLB (requester 0) and the
// DTLB (requester 1). One walk is in flight at a time; the PTE returned by
// the walker is routed back unmodified to the requester that owns the walk.
// Optional walk timeout is enabled by defining PTW_ARB_TIMEOUT_EN: a stuck
// walk is answered with a fault PTE and the late walker response is drained.
module ptw_arbiter
    import ptw_arb_pkg::*;
#(
    parameter int NUM_REQ        = ptw_arb_pkg::NUM_REQ,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*VADDR_W-1:0] req_vaddr_i,
    output logic [NUM_REQ-1:0]         resp_valid_o,
    input  logic [NUM_REQ-1:0]         resp_ready_i,
    output logic [PTE_W-1:0]           resp_pte_o,
    output logic                       ptw_req_valid_o,
    input  logic                       ptw_req_ready_i,
    output logic [VADDR_W-1:0]         ptw_vaddr_o,
    input  logic                       ptw_resp_valid_i,
    output logic                       ptw_resp_ready_o,
    input  logic [PTE_W-1:0]           ptw_pte_i
);

    // Only the two-requester arbiter exists, and the counter must reach the limit.
    if (NUM_REQ != 2 || (1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
        $error("ptw_arbiter: unsupported NUM_REQ/CNT_W/TIMEOUT_CYCLES combination");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic               r_owner;
    logic               w_owner_next;
    logic               r_last_grant;
    logic               w_last_grant_next;
    logic [VADDR_W-1:0] r_vaddr;
    logic [VADDR_W-1:0] w_vaddr_next;
    logic [PTE_W-1:0]   r_pte;
    logic [PTE_W-1:0]   w_pte_next;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_grant_idx;
    logic               w_timeout;
    logic               w_drain;
    logic [VADDR_W-1:0] w_req_vaddr [NUM_REQ];

    // Split the packed request address bus into one word per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_vaddr_unpack
        assign w_req_vaddr[gi] = req_vaddr_i[gi*VADDR_W +: VADDR_W];
    end

    rr_arb2 u_rr_arb2 (
        .req_valid_i  (req_valid_i),
        .last_grant_i (r_last_grant),
        .grant_o      (w_grant),
        .grant_idx_o  (w_grant_idx)
    );

`ifdef PTW_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_drain;

    // The limit is hit on the TIMEOUT_CYCLES-th WAIT cycle with no response;
    // a response in that same cycle wins.
    assign w_timeout = (r_state == WAIT) && !ptw_resp_valid_i
                    && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_drain   = r_drain;

    // Count silent WAIT cycles and remember that one stale response is owed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_drain <= 1'b0;
        end else begin
            if (r_state == ISSUE && ptw_req_valid_o && ptw_req_ready_i) begin
                r_cnt <= '0;
            end else if (r_state == WAIT && !ptw_resp_valid_i) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_drain <= 1'b1;
            end else if (r_drain && ptw_resp_valid_i) begin
                r_drain <= 1'b0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_drain   = 1'b0;
`endif

    // State and data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_vaddr      <= '0;
            r_pte        <= PTE_FAULT;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_grant <= w_last_grant_next;
            r_vaddr      <= w_vaddr_next;
            r_pte        <= w_pte_next;
        end
    end

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_grant_next = r_last_grant;
        w_vaddr_next      = r_vaddr;
        w_pte_next        = r_pte;
        req_ready_o       = '0;
        ptw_req_valid_o   = 1'b0;
        ptw_resp_ready_o  = w_drain;
        case (r_state)
            IDLE: begin
                req_ready_o = w_grant;
                if ((req_valid_i & w_grant) != '0) begin
                    w_owner_next = w_grant_idx;
                    w_vaddr_next = w_req_vaddr[w_grant_idx];
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                // A stale response must be drained before a new walk starts.
                ptw_req_valid_o = !w_drain;
                if (!w_drain && ptw_req_ready_i) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                ptw_resp_ready_o = 1'b1;
                if (ptw_resp_valid_i) begin
                    w_pte_next   = ptw_pte_i;
                    w_state_next = DELIVER;
                end else if (w_timeout) begin
                    w_pte_next   = PTE_FAULT;
                    w_state_next = DELIVER;
                end
            end
            DELIVER: begin
                if (resp_ready_i[r_owner]) begin
                    w_last_grant_next = r_owner;
                    w_state_next      = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Response valid goes only to the owner of the walk.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp_valid
        assign resp_valid_o[gi] = (r_state == DELIVER) && (r_owner == 1'(gi));
    end

    assign resp_pte_o  = (r_state == DELIVER) ? r_pte   : '0;
    assign ptw_vaddr_o = (r_state == ISSUE)   ? r_vaddr : '0;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Self-checking bench for ptw_arbiter: directed scenarios with literal
// expectations plus randomized client/walker traffic checked every cycle
// against a transaction-level model and an end-to-end PTE scoreboard.
// Define PTW_ARB_TIMEOUT_EN to also exercise the walk timeout (limit 8).
module tb_ptw_arbiter;

    localparam int TMO = 8;
`ifdef PTW_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid_i, req_ready_o, resp_valid_o, resp_ready_i;
    logic [63:0] req_vaddr_i;
    logic [31:0] resp_pte_o, ptw_vaddr_o, ptw_pte_i;
    logic        ptw_req_valid_o, ptw_req_ready_i, ptw_resp_valid_i, ptw_resp_ready_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    ptw_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(TMO), .CNT_W(9)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_vaddr_i      (req_vaddr_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_pte_o       (resp_pte_o),
        .ptw_req_valid_o  (ptw_req_valid_o),
        .ptw_req_ready_i  (ptw_req_ready_i),
        .ptw_vaddr_o      (ptw_vaddr_o),
        .ptw_resp_valid_i (ptw_resp_valid_i),
        .ptw_resp_ready_o (ptw_resp_ready_o),
        .ptw_pte_i        (ptw_pte_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walker's page-table contents: vaddrs with low bits 000 fault.
    function automatic logic [31:0] pte_of(input logic [31:0] va);
        if (va[2:0] == 3'b000) return 32'h0;
        return {va[31:12] ^ 20'h5A5A5, 12'h0C7};
    endfunction

    // ---------------- transaction-level reference model ----------------
    // m_ph: 0 no walk, 1 walk waiting for the PTW to take it,
    //       2 walk outstanding at the PTW, 3 PTE waiting for the client.
    int          m_ph = 0, m_cnt = 0;
    logic        m_own = 1'b0, m_last = 1'b1, m_drain = 1'b0;
    logic [31:0] m_va = 32'h0, m_pte = 32'h0;
    logic        m_win, m_dr_seen, e_prv, e_prr;
    logic [1:0]  e_rr, e_rv;
    logic [31:0] e_va, e_pte;

    initial begin
        forever begin
            @(negedge clk);
            m_win = (req_valid_i == 2'b11) ? ~m_last : req_valid_i[1];
            e_rr  = (m_ph == 0 && req_valid_i != 2'b00) ? (m_win ? 2'b10 : 2'b01) : 2'b00;
            e_prv = (m_ph == 1) && !m_drain;
            e_va  = (m_ph == 1) ? m_va : 32'h0;
            e_prr = (m_ph == 2) || m_drain;
            e_rv  = (m_ph == 3) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
            e_pte = (m_ph == 3) ? m_pte : 32'h0;
            if (chk_en) begin
                check("req_ready", req_ready_o, e_rr);
                check("ptw_req_valid", ptw_req_valid_o, e_prv);
                check("ptw_vaddr", ptw_vaddr_o, e_va);
                check("ptw_resp_ready", ptw_resp_ready_o, e_prr);
                check("resp_valid", resp_valid_o, e_rv);
                check("resp_pte", resp_pte_o, e_pte);
            end
            if (rst) begin
                m_ph = 0; m_own = 1'b0; m_last = 1'b1; m_drain = 1'b0;
                m_va = 32'h0; m_pte = 32'h0; m_cnt = 0;
            end else begin
                m_dr_seen = m_drain && ptw_resp_valid_i;
                case (m_ph)
                    0: if (e_rr != 2'b00) begin
                        m_own = m_win;
                        m_va  = m_win ? req_vaddr_i[63:32] : req_vaddr_i[31:0];
                        m_ph  = 1;
                    end
                    1: if (e_prv && ptw_req_ready_i) begin
                        m_ph = 2; m_cnt = 0;
                    end
                    2: if (ptw_resp_valid_i) begin
                        m_pte = ptw_pte_i; m_ph = 3;
                    end else if (TMO_EN) begin
                        m_cnt++;
                        if (m_cnt == TMO) begin
                            m_pte = 32'h0; m_ph = 3; m_drain = 1'b1;
                        end
                    end
                    default: if (resp_ready_i[m_own]) begin
                        m_last = m_own; m_ph = 0;
                    end
                endcase
                if (m_dr_seen) m_drain = 1'b0;
            end
        end
    end

    // Zero-wait walk with literal expectations on grant, address, PTE and latency.
    task automatic walk(input logic [1:0] v, input logic [63:0] va, input logic [31:0] pte,
                        input int exp_own, input string tag);
        logic [31:0] exp_va;
        exp_va = (exp_own == 1) ? va[63:32] : va[31:0];
        req_valid_i = v; req_vaddr_i = va; ptw_req_ready_i = 1'b1;
        resp_ready_i = 2'b11; ptw_resp_valid_i = 1'b0; ptw_pte_i = pte;
        #1 check({tag, "_grant"}, req_ready_o, (exp_own == 1) ? 2'b10 : 2'b01);
        tick(); #1 check({tag, "_issue"}, {ptw_req_valid_o, ptw_vaddr_o}, {1'b1, exp_va});
        tick(); ptw_resp_valid_i = 1'b1;
        #1 check({tag, "_wait"}, ptw_resp_ready_o, 1'b1);
        tick(); ptw_resp_valid_i = 1'b0; ptw_pte_i = 32'hFFFF_FFFF;
        #1 check({tag, "_deliver"}, {resp_valid_o, resp_pte_o}, {((exp_own == 1) ? 2'b10 : 2'b01), pte});
        tick(); req_valid_i = 2'b00;
        #1 check({tag, "_idle"}, {resp_valid_o, ptw_req_valid_o}, 3'b000);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid_i = 2'b00; req_vaddr_i = 64'h0; resp_ready_i = 2'b00;
        ptw_req_ready_i = 1'b0; ptw_resp_valid_i = 1'b0; ptw_pte_i = 32'h0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Random-traffic environment state
    logic        cl_req [2], cl_wait [2], late_for [2];
    logic [31:0] cl_va [2];
    logic        ptw_pend;
    logic [31:0] ptw_va;
    int          ptw_dly, n_resp;

    initial begin
        do_reset();
        chk_en = 1'b1;
        #1 check("reset_outputs",
                 {req_ready_o, resp_valid_o, resp_pte_o, ptw_req_valid_o, ptw_vaddr_o, ptw_resp_ready_o},
                 64'h0);

        // Single request from the ITLB
        walk(2'b01, {32'h0, 32'h0000_5123}, 32'h0ABC_D003, 0, "single");

        // Tie after reset: ITLB first, then strict alternation
        do_reset();
        for (int k = 0; k < 8; k++)
            walk(2'b11, {32'hD000_1000 + 32'(k << 12) + 32'h1, 32'h1000_0000 + 32'(k << 12) + 32'h2},
                 32'h0001_0000 + 32'(k), k % 2, $sformatf("rr%0d", k));

        // Back-pressure on the DTLB walk while the ITLB waits
        req_valid_i = 2'b10; req_vaddr_i = {32'h0000_7777, 32'h0000_1111};
        ptw_req_ready_i = 1'b0; resp_ready_i = 2'b11;
        tick(); req_valid_i = 2'b01;
        for (int k = 0; k < 5; k++) begin
            #1 check("bp_issue_hold", {req_ready_o, ptw_req_valid_o, ptw_vaddr_o}, {2'b00, 1'b1, 32'h0000_7777});
            tick();
        end
        ptw_req_ready_i = 1'b1;
        tick(); ptw_resp_valid_i = 1'b1; ptw_pte_i = 32'h0007_7001;
        tick(); ptw_resp_valid_i = 1'b0; ptw_pte_i = 32'h0; resp_ready_i = 2'b01;
        for (int k = 0; k < 4; k++) begin
            #1 check("bp_deliver_hold", {req_ready_o, resp_valid_o, resp_pte_o}, {2'b00, 2'b10, 32'h0007_7001});
            tick();
        end
        resp_ready_i = 2'b11;
        tick();
        // ITLB, still waiting, is now served and its walk faults
        walk(2'b01, {32'h0, 32'h0000_1111}, 32'h0, 0, "fault");

        // Reset in WAIT during a DTLB walk; afterwards the ITLB wins a tie
        req_valid_i = 2'b10; req_vaddr_i = {32'h0000_9999, 32'h0};
        ptw_req_ready_i = 1'b1;
        tick(); req_valid_i = 2'b00;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        #1 check("midwalk_reset",
                 {req_ready_o, resp_valid_o, resp_pte_o, ptw_req_valid_o, ptw_vaddr_o, ptw_resp_ready_o},
                 64'h0);
        walk(2'b11, {32'h0000_2222, 32'h0000_3333}, 32'h0003_3001, 0, "post_reset");

`ifdef PTW_ARB_TIMEOUT_EN
        begin
            int n;
            do_reset();
            req_valid_i = 2'b01; req_vaddr_i = {32'h0, 32'h0000_4444}; ptw_req_ready_i = 1'b1;
            tick(); req_valid_i = 2'b00;
            tick(); ptw_req_ready_i = 1'b0;   // now in WAIT, walker stays silent
            n = 0;
            while (resp_valid_o == 2'b00 && n < 40) begin
                tick(); n++;
            end
            check("tmo_wait_cycles", n, TMO);
            check("tmo_fault_pte", {resp_valid_o, resp_pte_o}, {2'b01, 32'h0});
            resp_ready_i = 2'b11;
            tick();
            req_valid_i = 2'b10; req_vaddr_i = {32'h0000_5555, 32'h0}; ptw_req_ready_i = 1'b1;
            tick(); req_valid_i = 2'b00;
            for (int k = 0; k < 3; k++) begin
                #1 check("tmo_issue_stall", {ptw_req_valid_o, ptw_resp_ready_o}, 2'b01);
                tick();
            end
            ptw_resp_valid_i = 1'b1; ptw_pte_i = 32'hDEAD_BEEF;
            tick(); ptw_resp_valid_i = 1'b0;
            #1 check("tmo_drained_issue", {ptw_req_valid_o, ptw_vaddr_o}, {1'b1, 32'h0000_5555});
            tick(); ptw_resp_valid_i = 1'b1; ptw_pte_i = 32'h0005_5001;
            tick(); ptw_resp_valid_i = 1'b0;
            #1 check("tmo_next_pte", {resp_valid_o, resp_pte_o}, {2'b10, 32'h0005_5001});
            tick();
        end
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 2; i++) begin
            cl_req[i] = 1'b0; cl_wait[i] = 1'b0; late_for[i] = 1'b0; cl_va[i] = 32'h0;
        end
        ptw_pend = 1'b0; ptw_va = 32'h0; ptw_dly = 0; n_resp = 0;
        for (int cyc = 0; cyc < 3500; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (req_valid_i[i] && req_ready_o[i]) begin
                    cl_req[i] = 1'b0; cl_wait[i] = 1'b1;
                end
                if (resp_valid_o[i] && resp_ready_i[i]) begin
                    check($sformatf("e2e_pte_req%0d", i), resp_pte_o,
                          late_for[i] ? 32'h0 : pte_of(cl_va[i]));
                    cl_wait[i] = 1'b0; n_resp++;
                end
            end
            if (ptw_resp_valid_i && ptw_resp_ready_o) ptw_pend = 1'b0;
            if (ptw_req_valid_o && ptw_req_ready_i) begin
                ptw_pend = 1'b1; ptw_va = ptw_vaddr_o;
                ptw_dly = (TMO_EN && $urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 3));
                for (int i = 0; i < 2; i++)
                    if (cl_wait[i] && cl_va[i] == ptw_va) late_for[i] = (ptw_dly > TMO);
            end
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (cyc < 3000 && !cl_req[i] && !cl_wait[i] && $urandom_range(0, 2) == 0) begin
                    cl_req[i] = 1'b1; cl_va[i] = $urandom; late_for[i] = 1'b0;
                end
                req_valid_i[i] = cl_req[i];
                req_vaddr_i[i*32 +: 32] = cl_req[i] ? cl_va[i] : $urandom;
            end
            if (ptw_pend && ptw_dly > 0) ptw_dly--;
            ptw_resp_valid_i = ptw_pend && ptw_dly == 0;
            ptw_pte_i        = ptw_resp_valid_i ? pte_of(ptw_va) : $urandom;
            ptw_req_ready_i  = !ptw_pend && ($urandom_range(0, 2) != 0);
            resp_ready_i     = 2'($urandom);
        end
        check("random_quiesced", {cl_req[0], cl_req[1], cl_wait[0], cl_wait[1]}, 4'b0000);
        check("random_enough_responses", n_resp > 200, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ptw_arbiter.md
Name: ptw_arbiter

Overview:
- Shares one page-table walker (PTW) between two TLB clients: requester 0 = ITLB, requester 1 = DTLB.
- Accepts miss requests from both clients and grants them round-robin.
- Forwards one walk at a time to the PTW and routes the returned PTE back to the owning client.
- Sits between the TLBs' PTW interfaces (valid/ready request and response channels) and the single walker.

Parameters:
- NUM_REQ, 2, number of requesters; fixed at 2 in this revision.
- TIMEOUT_CYCLES, 256, maximum WAIT-state cycles before a timeout fault; used only with the optional feature.
- CNT_W, 9, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  2  per-requester walk request valid
- req_ready_o  out  2  per-requester request accept (one-hot or zero)
- req_vaddr_i  in  64  {vaddr1, vaddr0}, 32 bits each
- resp_valid_o  out  2  per-requester PTE response valid
- resp_ready_i  in  2  per-requester response ready
- resp_pte_o  out  32  PTE returned to the owner (shared bus)
- ptw_req_valid_o  out  1  walk request to the PTW
- ptw_req_ready_i  in  1  PTW accepts request
- ptw_vaddr_o  out  32  walk virtual address
- ptw_resp_valid_i  in  1  PTW response valid
- ptw_resp_ready_o  out  1  arbiter ready for the PTW response
- ptw_pte_i  in  32  PTE from the PTW; all-zero means walk fault

Behaviour:
- Reset (rst=1 at posedge, synchronous, active-high, clock clk):
  - state=IDLE, owner=0, last_grant=1 (requester 0 wins the first tie), vaddr_q=0, pte_q=0.
  - All outputs 0: req_ready_o, resp_valid_o, resp_pte_o, ptw_req_valid_o, ptw_vaddr_o, ptw_resp_ready_o.
  - Reset mid-walk abandons the transaction with no response. The PTW must be reset in the same cycle.
- Outputs are decoded from registered state/owner/vaddr_q/pte_q. The only exception is req_ready_o, which is combinational in IDLE.
- IDLE:
  - Grant: if only one req_valid_i bit is set, that requester; if both are set, the requester != last_grant.
  - req_ready_o[grant]=1 in the same cycle. Transfer happens on valid&&ready.
  - On transfer: vaddr_q<=req_vaddr_i[grant*32+:32], owner<=grant, go to ISSUE.
  - No valid requests: stay in IDLE, req_ready_o=0.
- ISSUE: ptw_req_valid_o=1, ptw_vaddr_o=vaddr_q. On ptw_req_ready_i go to WAIT. Valid holds until accepted.
- WAIT: ptw_resp_ready_o=1. On ptw_resp_valid_i: pte_q<=ptw_pte_i, go to DELIVER.
- DELIVER:
  - resp_valid_o[owner]=1 and resp_pte_o=pte_q; the other bit stays 0.
  - On resp_ready_i[owner]: last_grant<=owner, go to IDLE.
  - resp_ready_i of the non-owner is ignored.
- req_ready_o is 0 outside IDLE, so a second request waits, holding its valid.
- Fairness: with both requesters continuously valid, grants strictly alternate; no starvation.
- Latency: with zero-wait PTW and client, request accepted at cycle N gives ptw_req_valid_o at N+1, resp_valid_o at N+3 (PTW responds in the cycle after accept), back to IDLE at N+4.
- The PTE is passed through unmodified; the zero-PTE fault convention is preserved end to end.

Optional Feature:
- Macro: PTW_ARB_TIMEOUT_EN.
- When defined:
  - A CNT_W-bit counter clears on entry to WAIT and increments each WAIT cycle without ptw_resp_valid_i.
  - When the counter reaches TIMEOUT_CYCLES: pte_q<=32'h0 (fault), go to DELIVER, set drain flag.
  - While drain=1: ptw_resp_ready_o=1 in every state and the ISSUE state stalls (ptw_req_valid_o=0).
  - The first ptw_resp_valid_i seen with drain=1 is discarded and clears drain.
  - A response arriving in the same cycle the counter hits the limit takes priority: it is delivered normally and no timeout occurs.
  - drain resets to 0.
- When undefined: no counter, WAIT is unbounded, and CNT_W and TIMEOUT_CYCLES are unused.

Decomposition:
- Package ptw_arb_pkg:
  - state encoding IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DELIVER=2'd3
  - NUM_REQ
  - PTE_FAULT=32'h0
  - VADDR_W=32, PTE_W=32
- Sub-module rr_arb2: combinational 2-way round-robin grant from req_valid_i and last_grant; outputs a one-hot grant and a grant index.
- The FSM, data registers and timeout logic stay in ptw_arbiter.

Test Plan:
- Single request: req_valid_i=2'b01, vaddr0=32'h0000_5123; PTW ready immediately, returns 32'h0ABC_D003 next cycle.
  - Expect ptw_vaddr_o=32'h0000_5123.
  - Expect resp_valid_o=2'b01, resp_pte_o=32'h0ABC_D003, 3 cycles after accept.
- Simultaneous requests after reset: req_valid_i=2'b11.
  - Expect requester 0 served first, then 1.
  - Repeat both continuously for 8 walks: grant order 0,1,0,1,...
- Back-pressure: ptw_req_ready_i=0 for 5 cycles, then resp_ready_i[1]=0 for 4 cycles.
  - Expect ptw_req_valid_o and ptw_vaddr_o stable.
  - Expect resp_valid_o=2'b10 held with constant PTE.
  - Expect req_ready_o=0 throughout.
- Fault passthrough: PTW returns 32'h0. Expect owner receives resp_pte_o=32'h0.
- Reset mid-walk: assert rst in WAIT.
  - Expect all outputs 0 next cycle, state IDLE.
  - A new request on requester 0 is granted first.
- With PTW_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, PTW never responds:
  - Expect resp_pte_o=32'h0 after 8 WAIT cycles.
  - Next walk stalls in ISSUE until one late PTW response is drained.
